// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode constants, the bubble word,
// the IF/ID pipeline payload and the fetch-stage state encoding.
package cpu_pkg;

    localparam int unsigned bit_width = 32;   // instruction, address and PC width
    localparam int unsigned IM_AW     = 8;    // instruction-memory index bits
    localparam int unsigned OPC_W     = 6;    // opcode field width

    // Primary opcodes (inst[31:26])
    localparam logic [OPC_W-1:0] OP_RTYPE    = 6'h00;
    localparam logic [OPC_W-1:0] OP_J        = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL      = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ      = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE      = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDI     = 6'h08;
    localparam logic [OPC_W-1:0] OP_LW       = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW       = 6'h2B;
    localparam logic [OPC_W-1:0] HALT_OPCODE = 6'h3F;

    // Bubble word: sll x0, x0, 0
    localparam logic [bit_width-1:0] NOP_WORD = 32'h0000_0000;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [bit_width-1:0] inst;
        logic [bit_width-1:0] pc;
        logic [bit_width-1:0] pc_plus1;
        logic                 valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        inst:     NOP_WORD,
        pc:       '0,
        pc_plus1: '0,
        valid:    1'b0
    };

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } fetch_state_e;

    // Opcode field of an instruction word
    function automatic logic [OPC_W-1:0] opcode_of(input logic [bit_width-1:0] inst);
        return inst[bit_width-1 -: OPC_W];
    endfunction

    function automatic logic is_halt(input logic [bit_width-1:0] inst);
        return opcode_of(inst) == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: hazard/branch control in, instruction-memory port,
// and the IF/ID register contents out to decode.
//   master : the fetch stage
//   slave  : the surrounding pipeline / instruction memory
interface if_fetch_stage_if;
    import cpu_pkg::*;

    // Control from hazard and branch units
    logic                 stall;
    logic                 flush;
    logic                 redirect_valid;
    logic [bit_width-1:0] redirect_target;

    // Instruction memory (combinational read)
    logic [bit_width-1:0] im_addr;
    logic [bit_width-1:0] im_data;

    // IF/ID register to decode
    logic [bit_width-1:0] if_id_inst;
    logic [bit_width-1:0] if_id_pc;
    logic [bit_width-1:0] if_id_pc_plus1;
    logic                 if_id_valid;
    logic                 halted;

    modport master (
        input  stall, flush, redirect_valid, redirect_target, im_data,
        output im_addr, if_id_inst, if_id_pc, if_id_pc_plus1, if_id_valid, halted
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_target, im_data,
        input  im_addr, if_id_inst, if_id_pc, if_id_pc_plus1, if_id_valid, halted
    );

endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter register with next-PC select.
//   clk, rst        : clock, synchronous active-high reset
//   stall           : hold the PC (hazard)
//   hold            : hold the PC (fetch frozen by hlt)
//   redirect_valid  : load redirect_target, overriding stall and hold
//   redirect_target : new PC, already reduced to IM_AW bits
//   pc              : current PC (word index)
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [bit_width-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             hold,
    input  logic             redirect_valid,
    input  logic [IM_AW-1:0] redirect_target,
    output logic [IM_AW-1:0] pc
);

    logic [IM_AW-1:0] pc_next;

    // Next-PC priority: redirect, then stall/halt hold, then increment (wraps)
    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (stall || hold) begin
            pc_next = pc;
        end else begin
            pc_next = pc + IM_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC[IM_AW-1:0];
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory address from the PC,
// applies stall/flush/redirect, registers the fetched word into IF/ID and
// freezes fetch after capturing a hlt instruction.
//   clk, rst : clock, synchronous active-high reset
//   ifc      : control in, instruction-memory port, IF/ID outputs, halted
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [bit_width-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    if_fetch_stage_if.master      ifc
);

    fetch_state_e     state_q;
    if_id_t           if_id_q;
    logic             halted_q;
    logic [IM_AW-1:0] pc;
    logic [IM_AW-1:0] pc_plus1;
    logic             unused_target_hi;

    // Target bits above the memory index are don't-care
    assign unused_target_hi = ^ifc.redirect_target[bit_width-1:IM_AW];

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .stall           (ifc.stall),
        .hold            (state_q == S_HALT),
        .redirect_valid  (ifc.redirect_valid),
        .redirect_target (ifc.redirect_target[IM_AW-1:0]),
        .pc              (pc)
    );

    // Link value wraps with the PC
    assign pc_plus1 = pc + IM_AW'(1);

    // IF/ID register and halt state; a redirect squashes any wrong-path hlt
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
            if_id_q  <= IF_ID_BUBBLE;
        end else if (ifc.redirect_valid) begin
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
            if_id_q  <= IF_ID_BUBBLE;
        end else if (ifc.flush) begin
            if_id_q  <= IF_ID_BUBBLE;
        end else if (ifc.stall) begin
            if_id_q  <= if_id_q;
        end else if (state_q == S_HALT) begin
            if_id_q  <= IF_ID_BUBBLE;
        end else begin
            if_id_q <= '{
                inst:     ifc.im_data,
                pc:       bit_width'(pc),
                pc_plus1: bit_width'(pc_plus1),
                valid:    1'b1
            };
            // hlt itself is delivered valid; fetch freezes behind it
            if (is_halt(ifc.im_data)) begin
                state_q  <= S_HALT;
                halted_q <= 1'b1;
            end
        end
    end

    assign ifc.im_addr        = bit_width'(pc);
    assign ifc.if_id_inst     = if_id_q.inst;
    assign ifc.if_id_pc       = if_id_q.pc;
    assign ifc.if_id_pc_plus1 = if_id_q.pc_plus1;
    assign ifc.if_id_valid    = if_id_q.valid;
    assign ifc.halted         = halted_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: table of {controls, expected outputs} plus
// hand-written halt/reset sequences, checked through an expectation queue.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    localparam logic [3:0] C_RUN   = 4'b0000;   // {rst, stall, flush, redirect}
    localparam logic [3:0] C_RST   = 4'b1000;
    localparam logic [3:0] C_STALL = 4'b0100;
    localparam logic [3:0] C_FLUSH = 4'b0010;
    localparam logic [3:0] C_RV    = 4'b0001;
    localparam logic [31:0] HLT    = 32'hFC00_0000;

    typedef struct {
        string       name;
        logic [3:0]  ctl;
        logic [31:0] rt;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcp1;
        logic        valid;
        logic        halted;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] imem [256];
    vec_t tbl[$];
    vec_t exp_q[$];
    int n_vec = 0;
    int n_miss = 0;
    logic unused_addr_hi;

    always #5 clk = ~clk;

    if_fetch_stage_if ifc ();

    if_fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    // Combinational instruction memory
    assign ifc.im_data = imem[ifc.im_addr[7:0]];
    assign unused_addr_hi = |ifc.im_addr[31:8];

    function automatic logic [31:0] mw(input int a);
        case (a)
            0:       return 32'h2001_0064;
            1:       return 32'hAC01_0001;
            40:      return 32'h2018_0018;
            default: return 32'h2000_0000 | 32'(a);
        endcase
    endfunction

    // Expect a real instruction fetched from word p
    function automatic vec_t vf(input string n, input logic [3:0] c, input logic [31:0] rt,
                                input int a, input int p, input logic h);
        vec_t v;
        v.name = n; v.ctl = c; v.rt = rt;
        v.addr = 32'(a); v.inst = mw(p); v.pc = 32'(p);
        v.pcp1 = 32'((p + 1) % 256); v.valid = 1'b1; v.halted = h;
        return v;
    endfunction

    // Expect a bubble in IF/ID
    function automatic vec_t vb(input string n, input logic [3:0] c, input logic [31:0] rt,
                                input int a, input logic h);
        vec_t v;
        v.name = n; v.ctl = c; v.rt = rt;
        v.addr = 32'(a); v.inst = 32'h0; v.pc = 32'h0;
        v.pcp1 = 32'h0; v.valid = 1'b0; v.halted = h;
        return v;
    endfunction

    // Drive one cycle of controls, queue its expectation, check after the edge
    task automatic step(input vec_t v);
        vec_t e;
        exp_q.push_back(v);
        rst                 = v.ctl[3];
        ifc.stall           = v.ctl[2];
        ifc.flush           = v.ctl[1];
        ifc.redirect_valid  = v.ctl[0];
        ifc.redirect_target = v.rt;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (ifc.im_addr !== e.addr || ifc.if_id_inst !== e.inst || ifc.if_id_pc !== e.pc ||
            ifc.if_id_pc_plus1 !== e.pcp1 || ifc.if_id_valid !== e.valid ||
            ifc.halted !== e.halted) begin
            n_miss++;
            $display("FAIL %s: got addr=%h inst=%h pc=%h pcp1=%h v=%b h=%b, want addr=%h inst=%h pc=%h pcp1=%h v=%b h=%b",
                     e.name, ifc.im_addr, ifc.if_id_inst, ifc.if_id_pc, ifc.if_id_pc_plus1,
                     ifc.if_id_valid, ifc.halted, e.addr, e.inst, e.pc, e.pcp1, e.valid, e.halted);
        end
        ifc.redirect_valid = 1'b0;
    endtask

    initial begin
        vec_t h;
        rst = 1'b0;
        ifc.stall = 1'b0;
        ifc.flush = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_target = '0;
        for (int i = 0; i < 256; i++) imem[i] = mw(i);

        // Reset, free run, stall, redirects, flush, wrap
        tbl.push_back(vb("reset",        C_RST,   0, 0, 1'b0));
        tbl.push_back(vf("run0",         C_RUN,   0, 1, 0, 1'b0));
        tbl.push_back(vf("run1",         C_RUN,   0, 2, 1, 1'b0));
        tbl.push_back(vf("run2",         C_RUN,   0, 3, 2, 1'b0));
        tbl.push_back(vf("run3",         C_RUN,   0, 4, 3, 1'b0));
        tbl.push_back(vf("run4",         C_RUN,   0, 5, 4, 1'b0));
        tbl.push_back(vf("stall_a",      C_STALL, 0, 5, 4, 1'b0));
        tbl.push_back(vf("stall_b",      C_STALL, 0, 5, 4, 1'b0));
        tbl.push_back(vf("resume",       C_RUN,   0, 6, 5, 1'b0));
        tbl.push_back(vf("run6",         C_RUN,   0, 7, 6, 1'b0));
        tbl.push_back(vb("stall_redir",  C_STALL | C_RV, 10, 10, 1'b0));
        tbl.push_back(vf("at10",         C_RUN,   0, 11, 10, 1'b0));
        tbl.push_back(vb("flush",        C_FLUSH, 0, 12, 1'b0));
        tbl.push_back(vf("after_flush",  C_RUN,   0, 13, 12, 1'b0));
        tbl.push_back(vb("redir38",      C_RV,    38, 38, 1'b0));
        tbl.push_back(vb("redir40",      C_RV,    40, 40, 1'b0));
        tbl.push_back(vf("at40",         C_RUN,   0, 41, 40, 1'b0));
        tbl.push_back(vb("redir254",     C_RV,    254, 254, 1'b0));
        tbl.push_back(vf("w254",         C_RUN,   0, 255, 254, 1'b0));
        tbl.push_back(vf("w255_wrap",    C_RUN,   0, 0, 255, 1'b0));
        tbl.push_back(vf("wrap0",        C_RUN,   0, 1, 0, 1'b0));
        tbl.push_back(vb("redir_hibits", C_RV,    32'h0000_0105, 5, 1'b0));
        tbl.push_back(vf("at5",          C_RUN,   0, 6, 5, 1'b0));
        tbl.push_back(vb("stall_flush",  C_STALL | C_FLUSH, 0, 6, 1'b0));
        tbl.push_back(vf("at6",          C_RUN,   0, 7, 6, 1'b0));

        foreach (tbl[i]) step(tbl[i]);

        // hlt at word 3: capture, freeze, release by redirect
        imem[3] = HLT;
        step(vb("h_redir2",   C_RV,    2, 2, 1'b0));
        step(vf("h_w2",       C_RUN,   0, 3, 2, 1'b0));
        h = vf("h_capture",   C_RUN,   0, 4, 3, 1'b1);
        h.inst = HLT;
        step(h);
        step(vb("h_frozen",   C_RUN,   0, 4, 1'b1));
        step(vb("h_stall",    C_STALL, 0, 4, 1'b1));
        step(vb("h_flush",    C_FLUSH, 0, 4, 1'b1));
        step(vb("h_release",  C_RV,    0, 0, 1'b0));
        step(vf("h_r0",       C_RUN,   0, 1, 0, 1'b0));
        step(vf("h_r1",       C_RUN,   0, 2, 1, 1'b0));
        step(vf("h_r2",       C_RUN,   0, 3, 2, 1'b0));
        // Flushed hlt is not captured and fetch continues
        step(vb("h_flushed",  C_FLUSH, 0, 4, 1'b0));
        step(vf("h_w4",       C_RUN,   0, 5, 4, 1'b0));

        // Reset while halted
        step(vb("r_redir2",   C_RV,    2, 2, 1'b0));
        step(vf("r_w2",       C_RUN,   0, 3, 2, 1'b0));
        step(h);
        step(vb("r_frozen",   C_RUN,   0, 4, 1'b1));
        step(vb("r_rst_halt", C_RST,   0, 0, 1'b0));
        step(vf("r_w0",       C_RUN,   0, 1, 0, 1'b0));
        step(vf("r_w1",       C_RUN,   0, 2, 1, 1'b0));
        // Reset while stalled
        step(vf("r_stall",    C_STALL, 0, 2, 1, 1'b0));
        step(vb("r_rst_stall", C_RST | C_STALL, 0, 0, 1'b0));
        step(vf("r_w0b",      C_RUN,   0, 1, 0, 1'b0));
        step(vf("r_w1b",      C_RUN,   0, 2, 1, 1'b0));
        step(vf("r_w2b",      C_RUN,   0, 3, 2, 1'b0));
        // Redirect while hlt is on im_data squashes it
        step(vb("sq_redir20", C_RV,    20, 20, 1'b0));
        step(vf("sq_w20",     C_RUN,   0, 21, 20, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
